pipeline_controller: RTL and testbench
======================================

PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 SHALL have port CLK  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port RESET  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
REQ-004 SHALL have ports id_uses_rs1, id_uses_rs2  in  1 each  ID instruction actually reads rs1/rs2.
REQ-005 SHALL have ports ex_mem_read  in  1 and ex_rd  in  5  load flag and destination of the instruction in EX.
REQ-006 SHALL have ports ex_branch_taken, ex_jump  in  1 each  resolved control transfer in EX.
REQ-007 SHALL have ports ex_muldiv_start  in  1 (EX holds multi-cycle DIV/DIVU/REM/REMU) and muldiv_done  in  1 (result valid this cycle).
REQ-008 SHALL have outputs pc_write, ifid_write, idex_write  1 each  register write enables (1 = load).
REQ-009 SHALL have outputs ifid_flush, idex_bubble, exmem_bubble  1 each  insert NOP (clear control bits) at next edge.
REQ-010 SHALL have outputs stall_cycles  16, flush_count  16, md_timeout  1  status.

Function
REQ-011 SHALL implement FSM states RUN and MD_WAIT; encoding in shared package.
REQ-012 Load-use hazard = RUN & ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)); SHALL then drive pc_write=0, ifid_write=0, idex_bubble=1, idex_write=1 for exactly that cycle; no state change.
REQ-013 Taken control transfer (ex_branch_taken|ex_jump) in RUN SHALL drive ifid_flush=1, idex_bubble=1, pc_write=1, ifid_write=1; overrides load-use in same cycle.
REQ-014 In RUN with ex_muldiv_start=1 and muldiv_done=0: pc_write=ifid_write=idex_write=0, exmem_bubble=1; next state MD_WAIT.
REQ-015 ex_muldiv_start=1 with muldiv_done=1 in same RUN cycle SHALL cause no stall and remain RUN.
REQ-016 In MD_WAIT with muldiv_done=0: same hold outputs as REQ-014; load-use and flush inputs ignored.
REQ-017 In MD_WAIT with muldiv_done=1: all write enables 1, no bubbles, next state RUN; ID hazard re-evaluated from following cycle.
REQ-018 Priority (highest first): MD_WAIT/muldiv hold, control-transfer flush, load-use stall, normal (all writes 1, no bubbles/flush).
REQ-019 6-bit watchdog SHALL clear on MD_WAIT entry, increment per MD_WAIT cycle; on reaching 63 without done: set md_timeout (sticky until reset), release hold as REQ-017, return RUN.
REQ-020 stall_cycles SHALL increment each cycle pc_write=0; flush_count each cycle ifid_flush=1; both saturate at 16'hFFFF.
REQ-021 Control outputs SHALL be combinational from state and inputs; no added latency.

Reset
REQ-022 RESET high SHALL immediately force state RUN, watchdog 0, stall_cycles 0, flush_count 0, md_timeout 0.
REQ-023 While RESET high: pc_write=ifid_write=idex_write=0, ifid_flush=idex_bubble=exmem_bubble=1.
REQ-024 RESET asserted mid-MD_WAIT SHALL abandon wait; first cycle after release is RUN.

Configuration
REQ-025 Macro MULDIV_STALL_EN: defined -> REQ-014..REQ-019 active; undefined -> ex_muldiv_start/muldiv_done ignored, MD_WAIT unreachable, watchdog absent, md_timeout tied 0.

Structure
REQ-026 Package pipeline_ctrl_pkg SHALL hold FSM state typedef, watchdog limit (63), counter widths.
REQ-027 SHALL contain one sub-module sat_counter (parameterised width, saturating increment, async clear) instantiated twice.

Verification
REQ-028 ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 -> one cycle pc_write=0, idex_bubble=1; stall_cycles 0->1.
REQ-029 Same as REQ-028 plus ex_branch_taken=1 -> ifid_flush=1, pc_write=1, flush_count +1, no stall.
REQ-030 ex_muldiv_start=1, muldiv_done 4 cycles later -> 4 hold cycles, exmem_bubble=1 each, stall_cycles=4, back to RUN.
REQ-031 ex_muldiv_start=1, muldiv_done never -> release after 64 stall cycles, md_timeout=1 until RESET.
REQ-032 RESET pulsed during MD_WAIT cycle 3 -> counters 0, RUN next cycle, bubbles high while RESET high.
REQ-033 ex_rd=0 with load and matching id_rs1=0 -> no stall.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared FSM encoding, watchdog limit and widths for pipeline_controller
package pipeline_ctrl_pkg;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MD_WAIT = 1'b1
    } ctrl_state_e;

    localparam int REG_W = 5;
    localparam int CNT_W = 16;
    localparam int WD_W  = 6;

    localparam logic [WD_W-1:0] WD_LIMIT = 6'd63;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with asynchronous clear
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipeline_controller.sv
// rtl/pipeline_controller.sv - load-use / control-transfer / muldiv stall controller
// Multi-cycle divide hold and its watchdog are built only when MULDIV_STALL_EN is defined.
module pipeline_controller
    import pipeline_ctrl_pkg::*;
(
    input  logic             CLK,
    input  logic             RESET,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_branch_taken,
    input  logic             ex_jump,
    input  logic             ex_muldiv_start,
    input  logic             muldiv_done,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_bubble,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic             md_timeout
);

    ctrl_state_e state_q;
    ctrl_state_e state_d;

    logic run;
    logic load_use;
    logic ctrl_xfer;
    logic md_hold;
    logic md_release;
    logic md_enter;

    assign run       = (state_q == ST_RUN);
    assign ctrl_xfer = run && (ex_branch_taken || ex_jump);
    assign load_use  = run && ex_mem_read && (ex_rd != '0) &&
                       ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                        (id_uses_rs2 && (id_rs2 == ex_rd)));

`ifdef MULDIV_STALL_EN
    logic [WD_W-1:0] wd_q;
    logic [WD_W-1:0] wd_d;
    logic            md_timeout_q;
    logic            md_timeout_d;

    // A watchdog expiry releases the pipeline exactly like a real done.
    always_comb begin
        md_hold      = 1'b0;
        md_release   = 1'b0;
        md_enter     = 1'b0;
        wd_d         = wd_q;
        md_timeout_d = md_timeout_q;
        if (state_q == ST_MD_WAIT) begin
            if (muldiv_done) begin
                md_release = 1'b1;
            end else if (wd_q == WD_LIMIT) begin
                md_release   = 1'b1;
                md_timeout_d = 1'b1;
            end else begin
                md_hold = 1'b1;
                wd_d    = wd_q + 6'd1;
            end
        end else if (ex_muldiv_start && !muldiv_done) begin
            md_hold  = 1'b1;
            md_enter = 1'b1;
            wd_d     = '0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wd_q         <= '0;
            md_timeout_q <= 1'b0;
        end else begin
            wd_q         <= wd_d;
            md_timeout_q <= md_timeout_d;
        end
    end

    assign md_timeout = md_timeout_q;
`else
    logic unused_md_inputs;

    assign unused_md_inputs = ex_muldiv_start ^ muldiv_done;
    assign md_hold          = 1'b0;
    assign md_release       = 1'b0;
    assign md_enter         = 1'b0;
    assign md_timeout       = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        if (md_enter) begin
            state_d = ST_MD_WAIT;
        end else if (md_release) begin
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Priority: reset, muldiv hold, release cycle (hazards ignored), flush, load-use.
    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        idex_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        if (RESET) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            exmem_bubble = 1'b1;
        end else if (md_hold) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_bubble = 1'b1;
        end else if (md_release) begin
            pc_write = 1'b1;
        end else if (ctrl_xfer) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .inc_i   (!pc_write),
        .count_o (stall_cycles)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .inc_i   (ifid_flush),
        .count_o (flush_count)
    );

endmodule

// File: tb/tb_pipeline_controller.sv
// tb/tb_pipeline_controller.sv - directed self-checking bench for pipeline_controller
module tb_pipeline_controller;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [4:0]  id_rs1 = '0;
    logic [4:0]  id_rs2 = '0;
    logic        id_uses_rs1 = 1'b0;
    logic        id_uses_rs2 = 1'b0;
    logic        ex_mem_read = 1'b0;
    logic [4:0]  ex_rd = '0;
    logic        ex_branch_taken = 1'b0;
    logic        ex_jump = 1'b0;
    logic        ex_muldiv_start = 1'b0;
    logic        muldiv_done = 1'b0;
    logic        pc_write;
    logic        ifid_write;
    logic        idex_write;
    logic        ifid_flush;
    logic        idex_bubble;
    logic        exmem_bubble;
    logic [15:0] stall_cycles;
    logic [15:0] flush_count;
    logic        md_timeout;

    int checks = 0;
    int failures = 0;

    // {pc_write, ifid_write, idex_write, ifid_flush, idex_bubble, exmem_bubble}
    localparam logic [5:0] O_NORMAL  = 6'b111_000;
    localparam logic [5:0] O_LOADUSE = 6'b001_010;
    localparam logic [5:0] O_FLUSH   = 6'b111_110;
    localparam logic [5:0] O_HOLD    = 6'b000_001;
    localparam logic [5:0] O_RESET   = 6'b000_111;

    logic [5:0] outs;
    assign outs = {pc_write, ifid_write, idex_write, ifid_flush, idex_bubble, exmem_bubble};

    pipeline_controller dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .ex_mem_read     (ex_mem_read),
        .ex_rd           (ex_rd),
        .ex_branch_taken (ex_branch_taken),
        .ex_jump         (ex_jump),
        .ex_muldiv_start (ex_muldiv_start),
        .muldiv_done     (muldiv_done),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .idex_write      (idex_write),
        .ifid_flush      (ifid_flush),
        .idex_bubble     (idex_bubble),
        .exmem_bubble    (exmem_bubble),
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count),
        .md_timeout      (md_timeout)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs1          = '0;
        id_rs2          = '0;
        id_uses_rs1     = 1'b0;
        id_uses_rs2     = 1'b0;
        ex_mem_read     = 1'b0;
        ex_rd           = '0;
        ex_branch_taken = 1'b0;
        ex_jump         = 1'b0;
        ex_muldiv_start = 1'b0;
        muldiv_done     = 1'b0;
    endtask

    task automatic set_load_use_rs2();
        ex_mem_read = 1'b1;
        ex_rd       = 5'd5;
        id_rs1      = 5'd3;
        id_uses_rs1 = 1'b1;
        id_rs2      = 5'd5;
        id_uses_rs2 = 1'b1;
    endtask

    initial begin
        cyc();
        cyc();
        chk("reset_outs", {10'd0, outs}, {10'd0, O_RESET});
        chk("reset_stall", stall_cycles, 16'd0);
        chk("reset_flush", flush_count, 16'd0);
        chk("reset_timeout", {15'd0, md_timeout}, 16'd0);

        RESET = 1'b0;
        #1;
        chk("idle_outs", {10'd0, outs}, {10'd0, O_NORMAL});
        cyc();
        chk("idle_stall", stall_cycles, 16'd0);

        set_load_use_rs2();
        #1;
        chk("lu_rs2_outs", {10'd0, outs}, {10'd0, O_LOADUSE});
        cyc();
        chk("lu_rs2_stall", stall_cycles, 16'd1);
        clear_inputs();
        #1;
        chk("after_lu_outs", {10'd0, outs}, {10'd0, O_NORMAL});

        ex_mem_read = 1'b1;
        ex_rd       = 5'd7;
        id_rs1      = 5'd7;
        id_uses_rs1 = 1'b0;
        #1;
        chk("lu_rs1_unused", {10'd0, outs}, {10'd0, O_NORMAL});
        id_uses_rs1 = 1'b1;
        #1;
        chk("lu_rs1_outs", {10'd0, outs}, {10'd0, O_LOADUSE});
        cyc();
        chk("lu_rs1_stall", stall_cycles, 16'd2);
        ex_mem_read = 1'b0;
        #1;
        chk("no_load_match", {10'd0, outs}, {10'd0, O_NORMAL});

        ex_mem_read = 1'b1;
        ex_rd       = 5'd0;
        id_rs1      = 5'd0;
        id_uses_rs1 = 1'b1;
        #1;
        chk("x0_no_stall", {10'd0, outs}, {10'd0, O_NORMAL});
        cyc();
        chk("x0_stall_cnt", stall_cycles, 16'd2);
        clear_inputs();

        set_load_use_rs2();
        ex_branch_taken = 1'b1;
        #1;
        chk("br_over_lu_outs", {10'd0, outs}, {10'd0, O_FLUSH});
        cyc();
        chk("br_flush_cnt", flush_count, 16'd1);
        chk("br_stall_cnt", stall_cycles, 16'd2);
        clear_inputs();
        ex_jump = 1'b1;
        #1;
        chk("jump_outs", {10'd0, outs}, {10'd0, O_FLUSH});
        cyc();
        chk("jump_flush_cnt", flush_count, 16'd2);
        clear_inputs();

`ifdef MULDIV_STALL_EN
        ex_muldiv_start = 1'b1;
        muldiv_done     = 1'b1;
        #1;
        chk("md_same_cycle", {10'd0, outs}, {10'd0, O_NORMAL});
        cyc();
        chk("md_same_stall", stall_cycles, 16'd2);
        clear_inputs();
        ex_jump = 1'b1;
        #1;
        chk("md_same_run", {10'd0, outs}, {10'd0, O_FLUSH});
        cyc();
        chk("md_same_flush", flush_count, 16'd3);
        clear_inputs();

        ex_muldiv_start = 1'b1;
        #1;
        chk("md_hold0", {10'd0, outs}, {10'd0, O_HOLD});
        cyc();
        set_load_use_rs2();
        ex_branch_taken = 1'b1;
        #1;
        chk("md_hold1_ignore", {10'd0, outs}, {10'd0, O_HOLD});
        cyc();
        clear_inputs();
        ex_muldiv_start = 1'b1;
        #1;
        chk("md_hold2", {10'd0, outs}, {10'd0, O_HOLD});
        cyc();
        chk("md_hold3", {10'd0, outs}, {10'd0, O_HOLD});
        cyc();
        muldiv_done = 1'b1;
        set_load_use_rs2();
        #1;
        chk("md_release", {10'd0, outs}, {10'd0, O_NORMAL});
        cyc();
        chk("md_stall_cnt", stall_cycles, 16'd6);
        chk("md_flush_cnt", flush_count, 16'd3);
        ex_muldiv_start = 1'b0;
        muldiv_done     = 1'b0;
        #1;
        chk("md_lu_after", {10'd0, outs}, {10'd0, O_LOADUSE});
        cyc();
        chk("md_lu_stall", stall_cycles, 16'd7);
        clear_inputs();

        ex_muldiv_start = 1'b1;
        for (int i = 0; i < 64; i++) begin
            #1;
            chk($sformatf("wd_hold%0d", i), {10'd0, outs}, {10'd0, O_HOLD});
            cyc();
        end
        chk("wd_release", {10'd0, outs}, {10'd0, O_NORMAL});
        chk("wd_timeout_pre", {15'd0, md_timeout}, 16'd0);
        cyc();
        ex_muldiv_start = 1'b0;
        #1;
        chk("wd_timeout", {15'd0, md_timeout}, 16'd1);
        chk("wd_stall_cnt", stall_cycles, 16'd71);
        chk("wd_run_outs", {10'd0, outs}, {10'd0, O_NORMAL});
        cyc();
        cyc();
        chk("wd_timeout_sticky", {15'd0, md_timeout}, 16'd1);

        ex_muldiv_start = 1'b1;
        cyc();
        cyc();
        cyc();
        chk("rst_md_pre", stall_cycles, 16'd74);
        RESET = 1'b1;
        #1;
        chk("rst_md_outs", {10'd0, outs}, {10'd0, O_RESET});
        chk("rst_md_stall", stall_cycles, 16'd0);
        chk("rst_md_flush", flush_count, 16'd0);
        chk("rst_md_timeout", {15'd0, md_timeout}, 16'd0);
        ex_muldiv_start = 1'b0;
        cyc();
        chk("rst_md_held", {10'd0, outs}, {10'd0, O_RESET});
        RESET = 1'b0;
        ex_branch_taken = 1'b1;
        #1;
        chk("rst_md_run", {10'd0, outs}, {10'd0, O_FLUSH});
        cyc();
        chk("rst_md_flush_cnt", flush_count, 16'd1);
        clear_inputs();
`else
        ex_muldiv_start = 1'b1;
        #1;
        chk("md_ignored0", {10'd0, outs}, {10'd0, O_NORMAL});
        cyc();
        chk("md_ignored1", {10'd0, outs}, {10'd0, O_NORMAL});
        cyc();
        chk("md_ign_stall", stall_cycles, 16'd2);
        chk("md_ign_timeout", {15'd0, md_timeout}, 16'd0);
        RESET = 1'b1;
        #1;
        chk("rst_outs", {10'd0, outs}, {10'd0, O_RESET});
        chk("rst_stall", stall_cycles, 16'd0);
        chk("rst_flush", flush_count, 16'd0);
        cyc();
        RESET = 1'b0;
        ex_muldiv_start = 1'b0;
        ex_branch_taken = 1'b1;
        #1;
        chk("rst_run", {10'd0, outs}, {10'd0, O_FLUSH});
        cyc();
        chk("rst_flush_cnt", flush_count, 16'd1);
        clear_inputs();
`endif

        #1;
        chk("final_outs", {10'd0, outs}, {10'd0, O_NORMAL});
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
